// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory (unified instruction/data RAM) between the
//   instruction-fetch requester (IF) and the load/store requester (D).
//   Each access is granted combinationally in IDLE. A store finishes in its
//   grant cycle. A read waits RD_LAT cycles and then routes mem_rdata back to
//   the port that issued it.
//
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//   Undefined (default): D always beats IF on simultaneous requests.
//   Defined:             ties go to the port opposite to the last grant.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   if_req/if_addr              fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata   fetch accept, read valid, read data
//   d_req/d_we/d_addr/d_wdata   load/store request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata      data accept, load valid, load data
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata   memory interface
//   busy                        high while a read is in flight (WAIT)
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_t;

  localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

  state_t          state_q, state_d;
  logic [3:0]      lat_cnt_q, lat_cnt_d;
  owner_t          owner_q, owner_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, d_rdata_q;

  logic tie_to_d;
  logic grant_d;
  logic grant_if;
  logic resp;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  owner_t last_owner_q, last_owner_d;

  // Round robin: on a tie the port that did not win last time goes first.
  always_comb begin
    tie_to_d     = (last_owner_q == OWN_IF);
    last_owner_d = last_owner_q;
    if (grant_d) begin
      last_owner_d = OWN_D;
    end else if (grant_if) begin
      last_owner_d = OWN_IF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= OWN_IF;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  // Fixed priority: loads/stores always win a tie against fetches.
  assign tie_to_d = 1'b1;
`endif

  // Grants are only possible in IDLE. They are also forced low while reset
  // is asserted so that every output reads 0 during reset.
  assign grant_d  = rst_n && (state_q == ST_IDLE) && d_req && (!if_req || tie_to_d);
  assign grant_if = rst_n && (state_q == ST_IDLE) && if_req && !grant_d;
  assign resp     = (state_q == ST_WAIT) && (lat_cnt_q == 4'd0);

  // Next-state logic plus all combinational outputs. A store never leaves
  // IDLE. A read waits RD_LAT cycles. The last WAIT cycle is the response.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    owner_d   = owner_q;
    if_gnt    = grant_if;
    d_gnt     = grant_d;
    mem_en    = grant_d || grant_if;
    mem_we    = grant_d && d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state_q == ST_WAIT);
    if_rvalid = resp && (owner_q == OWN_IF);
    d_rvalid  = resp && (owner_q == OWN_D);
    if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    d_rdata   = d_rvalid ? mem_rdata : d_rdata_q;

    if (grant_d) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (grant_if) begin
      mem_addr  = if_addr;
    end

    case (state_q)
      ST_IDLE: begin
        if ((grant_d && !d_we) || grant_if) begin
          state_d   = ST_WAIT;
          lat_cnt_d = LAT_INIT;
          owner_d   = grant_d ? OWN_D : OWN_IF;
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          lat_cnt_d = lat_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register. Reset abandons any read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lat_cnt_q <= 4'd0;
      owner_q   <= OWN_IF;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      owner_q   <= owner_d;
    end
  end

  // Each port keeps showing its last returned word until its next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (if_rvalid) begin
        if_rdata_q <= mem_rdata;
      end
      if (d_rvalid) begin
        d_rdata_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed steps followed by random request traffic. Expected values come
//   from a transaction-level model: one outstanding read with a scheduled
//   response cycle, a reference memory array and per-port held read data.
module tb_mem_port_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(RD_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  function automatic logic [DW-1:0] memInit(input int idx);
    logic [15:0] a;
    a = 16'(idx);
    return {a ^ 16'h5A5A, ~a};
  endfunction

  // Memory device: 1024 words, read data appears RD_LAT cycles after a strobe.
  logic [DW-1:0] devMem [1024];
  logic [DW-1:0] rdPipe [RD_LAT];
  logic          devInit = 1'b0;

  always @(posedge clk) begin
    if (!devInit) begin
      for (int i = 0; i < 1024; i++) devMem[i] <= memInit(i);
      devMem[4] <= 32'h0013_0093;
      devInit <= 1'b1;
    end else if (mem_en && mem_we) begin
      devMem[mem_addr[11:2]] <= mem_wdata;
    end
    rdPipe[0] <= (mem_en && !mem_we) ? devMem[mem_addr[11:2]] : '0;
    for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
  end

  assign mem_rdata = rdPipe[RD_LAT-1];

  // Reference model state.
  logic [DW-1:0] refMem [1024];
  int            cyc;
  bit            respPending;
  int            respCycle;
  bit            respPortD;
  logic [DW-1:0] respData;
  bit            lastD;
  logic [DW-1:0] heldIf, heldD;
  bit            eIfGnt, eDGnt;

  // Sampled DUT outputs of the most recent cycle.
  logic          sIfGnt, sDGnt, sIfRv, sDRv, sBusy, sEn, sWe;
  logic [AW-1:0] sAddr;
  logic [DW-1:0] sWdata, sIfRdata, sDRdata;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    respPending = 1'b0;
    lastD       = 1'b0;
    heldIf      = '0;
    heldD       = '0;
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_if_gnt", 32'(if_gnt), 32'd0);
    checkOutput("rst_d_gnt", 32'(d_gnt), 32'd0);
    checkOutput("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    checkOutput("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_if_rdata", if_rdata, 32'd0);
    checkOutput("rst_d_rdata", d_rdata, 32'd0);
  endtask

  // One clock cycle: drive requests, predict, sample at negedge, compare,
  // advance the model. Called at posedge+1 and returns at the next posedge+1.
  task automatic applyStimulus(input bit ifr, input logic [AW-1:0] ia, input bit dr,
                               input bit dwe, input logic [AW-1:0] da, input logic [DW-1:0] dd);
    bit tieD, winD, winIf, respNow;
    bit eEn, eWe, eIfRv, eDRv, eBusy;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eIfRdata, eDRdata;
    if_req  = ifr;
    if_addr = ia;
    d_req   = dr;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dd;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    tieD = !lastD;
`else
    tieD = 1'b1;
`endif
    respNow  = respPending && (respCycle == cyc);
    winD     = !respPending && dr && (!ifr || tieD);
    winIf    = !respPending && ifr && !winD;
    eIfGnt   = winIf;
    eDGnt    = winD;
    eEn      = winD || winIf;
    eWe      = winD && dwe;
    eAddr    = winD ? da : ia;
    eBusy    = respPending;
    eIfRv    = respNow && !respPortD;
    eDRv     = respNow && respPortD;
    eIfRdata = eIfRv ? respData : heldIf;
    eDRdata  = eDRv ? respData : heldD;

    @(negedge clk);
    sIfGnt = if_gnt;  sDGnt = d_gnt;  sIfRv = if_rvalid;  sDRv = d_rvalid;
    sBusy = busy;  sEn = mem_en;  sWe = mem_we;  sAddr = mem_addr;  sWdata = mem_wdata;
    sIfRdata = if_rdata;  sDRdata = d_rdata;

    checkOutput("if_gnt", 32'(sIfGnt), 32'(eIfGnt));
    checkOutput("d_gnt", 32'(sDGnt), 32'(eDGnt));
    checkOutput("if_rvalid", 32'(sIfRv), 32'(eIfRv));
    checkOutput("d_rvalid", 32'(sDRv), 32'(eDRv));
    checkOutput("busy", 32'(sBusy), 32'(eBusy));
    checkOutput("mem_en", 32'(sEn), 32'(eEn));
    checkOutput("mem_we", 32'(sWe), 32'(eWe));
    checkOutput("if_rdata", sIfRdata, eIfRdata);
    checkOutput("d_rdata", sDRdata, eDRdata);
    if (eEn) checkOutput("mem_addr", sAddr, eAddr);
    if (eWe) checkOutput("mem_wdata", sWdata, dd);

    if (respNow) begin
      if (respPortD) heldD = respData;
      else heldIf = respData;
      respPending = 1'b0;
    end
    if (eEn) lastD = winD;
    if (eWe) begin
      refMem[da[11:2]] = dd;
    end else if (eEn) begin
      respPending = 1'b1;
      respCycle   = cyc + RD_LAT;
      respPortD   = winD;
      respData    = refMem[eAddr[11:2]];
    end

    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    bit            ifP, dP, dWeP;
    logic [AW-1:0] iaP, daP;
    logic [DW-1:0] ddP;

    for (int i = 0; i < 1024; i++) refMem[i] = memInit(i);
    refMem[4] = 32'h0013_0093;
    modelReset();
    cyc = 0;

    // Reset with no requests, then five idle cycles.
    rst_n = 1'b0;  if_req = 1'b0;  if_addr = '0;
    d_req = 1'b0;  d_we = 1'b0;  d_addr = '0;  d_wdata = '0;
    #2;
    checkResetOutputs();
    #7;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) applyStimulus(0, '0, 0, 0, '0, '0);

    // Single fetch from 0x10.
    applyStimulus(1, 32'h10, 0, 0, '0, '0);
    checkOutput("fetch_gnt", 32'(sIfGnt), 32'd1);
    checkOutput("fetch_mem_en", 32'(sEn), 32'd1);
    checkOutput("fetch_mem_addr", sAddr, 32'h10);
    applyStimulus(0, '0, 0, 0, '0, '0);
    checkOutput("fetch_busy_t1", 32'(sBusy), 32'd1);
    applyStimulus(0, '0, 0, 0, '0, '0);
    checkOutput("fetch_rvalid_t2", 32'(sIfRv), 32'd1);
    checkOutput("fetch_rdata_t2", sIfRdata, 32'h0013_0093);
    applyStimulus(0, '0, 0, 0, '0, '0);
    checkOutput("fetch_idle_t3", 32'(sBusy), 32'd0);

    // Back-to-back stores.
    applyStimulus(0, '0, 1, 1, 32'h100, 32'hDEAD_BEEF);
    checkOutput("st1_gnt", 32'(sDGnt), 32'd1);
    checkOutput("st1_mem_we", 32'(sWe), 32'd1);
    checkOutput("st1_wdata", sWdata, 32'hDEAD_BEEF);
    checkOutput("st1_busy", 32'(sBusy), 32'd0);
    applyStimulus(0, '0, 1, 1, 32'h104, 32'h1234_5678);
    checkOutput("st2_gnt", 32'(sDGnt), 32'd1);

    // Simultaneous fetch and load, twice: grant order D, IF, D, IF.
    for (int rep = 0; rep < 2; rep++) begin
      applyStimulus(1, 32'h20, 1, 0, 32'h104, '0);
      checkOutput("tie_d_first", 32'(sDGnt), 32'd1);
      checkOutput("tie_if_waits", 32'(sIfGnt), 32'd0);
      applyStimulus(1, 32'h20, 0, 0, '0, '0);
      applyStimulus(1, 32'h20, 0, 0, '0, '0);
      checkOutput("tie_d_rvalid", 32'(sDRv), 32'd1);
      checkOutput("tie_no_if_rvalid", 32'(sIfRv), 32'd0);
      checkOutput("tie_d_rdata", sDRdata, 32'h1234_5678);
      applyStimulus(1, 32'h20, 0, 0, '0, '0);
      checkOutput("tie_if_second", 32'(sIfGnt), 32'd1);
      applyStimulus(0, '0, 0, 0, '0, '0);
      applyStimulus(0, '0, 0, 0, '0, '0);
      checkOutput("tie_if_rvalid", 32'(sIfRv), 32'd1);
    end

    // Reset pulsed during WAIT after a fetch grant.
    applyStimulus(1, 32'h30, 0, 0, '0, '0);
    if_req = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checkResetOutputs();
    #1;
    if_req = 1'b0;
    rst_n  = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    cyc++;
    applyStimulus(1, 32'h30, 0, 0, '0, '0);
    checkOutput("no_stale_rvalid", 32'(sIfRv), 32'd0);
    checkOutput("reissue_gnt", 32'(sIfGnt), 32'd1);
    applyStimulus(0, '0, 0, 0, '0, '0);
    applyStimulus(0, '0, 0, 0, '0, '0);
    checkOutput("reissue_rvalid", 32'(sIfRv), 32'd1);
    checkOutput("reissue_rdata", sIfRdata, memInit(12));

    // Random traffic: each requester holds its request until granted.
    ifP = 1'b0;  dP = 1'b0;  dWeP = 1'b0;
    iaP = '0;  daP = '0;  ddP = '0;
    for (int n = 0; n < 400; n++) begin
      if (!ifP && ($urandom_range(0, 2) == 0)) begin
        ifP = 1'b1;
        iaP = 32'h200 + (32'($urandom_range(0, 15)) << 2);
      end
      if (!dP && ($urandom_range(0, 2) == 0)) begin
        dP   = 1'b1;
        dWeP = 1'($urandom_range(0, 1));
        daP  = 32'h200 + (32'($urandom_range(0, 15)) << 2);
        ddP  = $urandom;
      end
      applyStimulus(ifP, iaP, dP, dWeP, daP, ddP);
      if (eIfGnt) ifP = 1'b0;
      if (eDGnt) dP = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory (unified instruction/data RAM) between two requesters:
  - the instruction-fetch stage (IF port);
  - the load/store path driven by the control unit's mem_write / result_src decode (D port).
- Sequences each access: grant, fixed-latency read wait, response routing back to the owner.
- Raises a busy indication so the PC/pipeline can stall.
- Sits between the fetch/datapath and the memory model.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- RD_LAT, 2, memory read latency in cycles, legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_WIDTH  fetch address, stable while if_req
- if_gnt  out  1  fetch accepted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  DATA_WIDTH  fetch read data
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  load data valid
- d_rdata  out  DATA_WIDTH  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid RD_LAT cycles after a read strobe
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values (async on rst_n low, regardless of clk):
  - state = IDLE, lat_cnt = 0, owner = IF, last_owner = IF.
  - All gnt, rvalid, mem_en, mem_we and busy are 0.
  - rdata outputs are 0.
- State IDLE:
  - If neither req is high: mem_en = 0, stay IDLE.
  - Otherwise pick a winner (priority rules below):
    - Same cycle, combinationally: assert winner's gnt; drive mem_en = 1, mem_addr and mem_wdata from the winner; mem_we = d_we if the winner is D, else 0.
    - The loser's gnt is 0 and it must keep req asserted.
  - Winner is D with d_we = 1 (store): the write completes in the grant cycle; next state IDLE; no rvalid is generated.
  - Otherwise (read): owner <= winner, lat_cnt <= RD_LAT-1, next state WAIT.
- State WAIT:
  - mem_en = 0, no grants.
  - lat_cnt decrements each cycle.
  - When lat_cnt == 0 in WAIT, the response cycle (grant cycle + RD_LAT):
    - assert the owner's rvalid for exactly one cycle;
    - the owner's rdata = mem_rdata, combinational pass-through;
    - next state IDLE.
- Throughput:
  - One read per RD_LAT+1 cycles.
  - Back-to-back stores: one per cycle.
  - A new grant is possible in the cycle after rvalid.
- Priority, default build: fixed; D beats IF on simultaneous requests. IF may starve under continuous D traffic (acceptable: pipeline back-pressure bounds it).
- last_owner updates on every grant.
- The non-owner's rvalid is always 0.
- The non-owner's rdata is held at its last value.
- Requests arriving during WAIT are ignored until IDLE (no queueing).
- busy = (state == WAIT); pipeline stall = busy | (if_req & ~if_gnt) | (d_req & ~d_gnt), formed outside this block.
- Reset mid-WAIT:
  - access abandoned, no rvalid is ever issued for it;
  - requesters re-issue after reset.
- d_req with d_we = 1 and RD_LAT irrelevant: a store never enters WAIT.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: on simultaneous IF and D requests, grant the port opposite to last_owner. Reset last_owner = IF, so D wins the first tie.
- Single requests are granted immediately as usual.
- Not defined: fixed D-over-IF priority as above; last_owner is unused (may be optimised away).

Test Plan:
- Reset then idle (RD_LAT=2): no reqs for 5 cycles -> mem_en=0, busy=0, all gnt/rvalid 0.
- Single fetch, if_addr=0x0000_0010, memory returns 0x0013_0093:
  - if_gnt and mem_en high in cycle T;
  - busy high at T+1;
  - if_rvalid=1 with if_rdata=0x0013_0093 at T+2;
  - IDLE at T+3.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF -> same-cycle d_gnt, mem_en=1, mem_we=1, busy stays 0; back-to-back second store granted the next cycle.
- Simultaneous if_req and d_req (load 0x104), default build -> d_gnt first; if_gnt 3 cycles later (RD_LAT+1); d_rvalid only, never if_rvalid, for the D access.
- Same stimulus repeated twice with MEM_ARB_ROUND_ROBIN_EN defined -> grant order D, IF, D, IF.
- rst_n pulsed low in the WAIT cycle after a fetch grant -> no if_rvalid afterwards, all outputs 0 immediately; re-issued fetch completes normally.
